// File: rtl/mmio_responder_if.sv
// Core-side memory port: one request/acknowledge transfer of one byte.
// The core drives the request side (master); mmio_responder answers (slave).
interface mmio_responder_if;
    logic       req;    // request, held until ack
    logic       we;     // 1 = store, 0 = load/fetch
    logic [7:0] addr;   // byte address
    logic [7:0] wdata;  // store data
    logic [7:0] rdata;  // load data, non-zero only while ack is high
    logic       ack;    // one-cycle completion pulse

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mmio_responder.sv
// Memory-side responder for the 8-bit core: RAM plus a small I/O window
// (button events, live buttons, DIP switches, LED register) at 0xFC..0xFF.
// Board inputs are synchronized and debounced here; button presses are
// latched as sticky events that clear when 0xFC is read.
module mmio_responder #(
    parameter int RAM_WORDS       = 252,     // RAM at 0x00..RAM_WORDS-1, at most 252
    parameter int DEBOUNCE_CYCLES = 120000,  // stable cycles before a debounced bit moves
    parameter int CNT_W           = 17       // 2**CNT_W must exceed DEBOUNCE_CYCLES
) (
    input  logic                   CLK_12MHz,
    input  logic                   Reset,
    mmio_responder_if.slave        bus,
    input  logic [5:0]             Switch,    // push-buttons, 0 = pressed
    input  logic [7:0]             DPSwitch,  // DIP switches, 1 = on
    output logic [7:0]             LED
);

    localparam int               N_IN      = 14;  // 6 buttons + 8 DIP bits
    localparam int               RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [7:0]       RAM_LIMIT = 8'(RAM_WORDS);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [7:0] ADDR_EVENTS  = 8'hFC;
    localparam logic [7:0] ADDR_BUTTONS = 8'hFD;
    localparam logic [7:0] ADDR_DIP     = 8'hFE;
    localparam logic [7:0] ADDR_LED     = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t           state, state_next;
    logic             capture;
    logic             we_q;
    logic [7:0]       addr_q;
    logic [7:0]       wdata_q;
    logic [7:0]       read_val;
    logic             ram_we, led_we, ev_clear;
    logic [RAM_AW-1:0] ram_idx;
    logic [7:0]       ram [RAM_WORDS];

    // Input conditioning. Buttons are inverted on entry so every stage holds
    // "pressed" polarity and the all-zero reset state means "released".
    logic [N_IN-1:0]  raw_in;
    logic [N_IN-1:0]  sync1, sync2;
    logic [N_IN-1:0]  db, db_next;
    logic [CNT_W-1:0] cnt [N_IN];
    logic [CNT_W-1:0] cnt_next [N_IN];
    logic [5:0]       pressed, rise;
    logic [7:0]       dip;
    logic [5:0]       ev;

    assign raw_in  = {DPSwitch, ~Switch};
    assign pressed = db[5:0];
    assign dip     = db[13:6];
    // A press is registered on the same edge its debounced bit rises.
    assign rise    = db_next[5:0] & ~db[5:0];

    assign ram_idx  = addr_q[RAM_AW-1:0];
    assign ram_we   = (state == RESP) && we_q && (addr_q < RAM_LIMIT);
    assign led_we   = (state == RESP) && we_q && (addr_q == ADDR_LED);
    assign ev_clear = (state == RESP) && !we_q && (addr_q == ADDR_EVENTS);

    // Handshake state register; Reset drops any transfer in flight.
    always_ff @(posedge CLK_12MHz or posedge Reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order between blocks.
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and bus outputs: accept in IDLE, answer for one cycle in RESP.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would infer a latch.
        state_next = state;
        capture    = 1'b0;
        bus.ack    = 1'b0;
        bus.rdata  = 8'h00;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.ack    = 1'b1;
                if (!we_q) bus.rdata = read_val;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture: addr/we/wdata frozen when IDLE accepts a request.
    always_ff @(posedge CLK_12MHz or posedge Reset) begin
        if (Reset) begin
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
        end else if (capture) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    // Load data mux over the full 8-bit address map; unmapped reads give 0.
    always_comb begin
        read_val = 8'h00;
        if (addr_q < RAM_LIMIT) begin
            read_val = ram[ram_idx];
        end else begin
            case (addr_q)
                ADDR_EVENTS:  read_val = {2'b00, ev};
                ADDR_BUTTONS: read_val = {2'b00, pressed};
                ADDR_DIP:     read_val = dip;
                ADDR_LED:     read_val = LED;
                default:      read_val = 8'h00;
            endcase
        end
    end

    // RAM write port, committed on the RESP edge of a store.
    always_ff @(posedge CLK_12MHz) begin
        // NOTE: the array has no reset; clearing it would turn the RAM into
        // flops, and software must initialise what it reads.
        if (ram_we) ram[ram_idx] <= wdata_q;
    end

    // LED register, written by stores to 0xFF.
    always_ff @(posedge CLK_12MHz or posedge Reset) begin
        if (Reset)       LED <= 8'h00;
        else if (led_we) LED <= wdata_q;
    end

    // Per-bit debounce: count mismatched cycles, adopt the input at CNT_MAX.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            db_next[i]  = db[i];
            cnt_next[i] = cnt[i];
            if (sync2[i] == db[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                db_next[i]  = sync2[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Two-flop synchronizer and debounce state.
    always_ff @(posedge CLK_12MHz or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            cnt   <= '{default: '0};
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            db    <= db_next;
            cnt   <= cnt_next;
        end
    end

    // Sticky button events; a press on the clearing edge survives the clear.
    always_ff @(posedge CLK_12MHz or posedge Reset) begin
        if (Reset) ev <= 6'b0;
        else       ev <= (ev & ~{6{ev_clear}}) | rise;
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with a short debounce window.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mmio_responder;

    logic       CLK_12MHz = 1'b0;
    logic       Reset;
    logic [5:0] Switch;
    logic [7:0] DPSwitch;
    logic [7:0] LED;

    int checks   = 0;
    int failures = 0;

    mmio_responder_if bus();

    mmio_responder #(
        .RAM_WORDS      (64),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .CLK_12MHz(CLK_12MHz),
        .Reset    (Reset),
        .bus      (bus),
        .Switch   (Switch),
        .DPSwitch (DPSwitch),
        .LED      (LED)
    );

    always #5 CLK_12MHz = ~CLK_12MHz;

    // One transfer started at a falling edge; returns to a falling edge with
    // the responder back in IDLE.
    task automatic bus_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                            output logic ack_pre, output logic ack_seen,
                            output logic ack_post, output logic [7:0] rd);
        ack_pre   = bus.ack;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge CLK_12MHz);
        ack_seen  = bus.ack;
        rd        = bus.rdata;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        @(negedge CLK_12MHz);
        ack_post  = bus.ack;
    endtask

    task automatic apply_reset();
        @(negedge CLK_12MHz);
        Reset = 1'b1;
        @(negedge CLK_12MHz);
        @(negedge CLK_12MHz);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        logic ap, as, apo;
        logic [7:0] rd;
        Reset = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.wdata = 8'h00;
        Switch = 6'h3F; DPSwitch = 8'h00;
        repeat (2) @(negedge CLK_12MHz);
        checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.ack); end
        checks++; if (bus.rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", bus.rdata); end
        checks++; if (LED !== 8'h00) begin failures++; $display("FAIL reset_led got=%h exp=00", LED); end
        Reset = 1'b0;
        @(negedge CLK_12MHz);
        bus_xfer(1'b0, 8'hFD, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_buttons got=%h exp=00", rd); end
        bus_xfer(1'b0, 8'hFE, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_dip got=%h exp=00", rd); end
        bus_xfer(1'b0, 8'hFC, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_events got=%h exp=00", rd); end
    endtask

    task automatic test_ram();
        logic ap, as, apo;
        logic [7:0] rd;
        bus_xfer(1'b1, 8'h10, 8'hA5, ap, as, apo, rd);
        checks++; if (ap !== 1'b0) begin failures++; $display("FAIL store_ack_early got=%b exp=0", ap); end
        checks++; if (as !== 1'b1) begin failures++; $display("FAIL store_ack_latency got=%b exp=1", as); end
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL store_rdata got=%h exp=00", rd); end
        checks++; if (apo !== 1'b0) begin failures++; $display("FAIL store_ack_width got=%b exp=0", apo); end
        bus_xfer(1'b0, 8'h10, 8'h00, ap, as, apo, rd);
        checks++; if (as !== 1'b1) begin failures++; $display("FAIL load_ack got=%b exp=1", as); end
        checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL load_10 got=%h exp=a5", rd); end
        checks++; if (LED !== 8'h00) begin failures++; $display("FAIL led_untouched got=%h exp=00", LED); end
        // Last RAM word, then the first unmapped address which must not alias word 0.
        bus_xfer(1'b1, 8'h00, 8'h12, ap, as, apo, rd);
        bus_xfer(1'b1, 8'h3F, 8'hC3, ap, as, apo, rd);
        bus_xfer(1'b0, 8'h3F, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'hC3) begin failures++; $display("FAIL load_last_ram got=%h exp=c3", rd); end
        bus_xfer(1'b1, 8'h40, 8'h55, ap, as, apo, rd);
        checks++; if (as !== 1'b1) begin failures++; $display("FAIL unmapped_store_ack got=%b exp=1", as); end
        bus_xfer(1'b0, 8'h40, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL unmapped_load got=%h exp=00", rd); end
        bus_xfer(1'b0, 8'h00, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h12) begin failures++; $display("FAIL no_alias_word0 got=%h exp=12", rd); end
        bus_xfer(1'b0, 8'hFB, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL unmapped_fb got=%h exp=00", rd); end
    endtask

    task automatic test_led();
        logic ap, as, apo;
        logic [7:0] rd;
        bus_xfer(1'b1, 8'hFF, 8'h3C, ap, as, apo, rd);
        checks++; if (LED !== 8'h3C) begin failures++; $display("FAIL led_store got=%h exp=3c", LED); end
        bus_xfer(1'b0, 8'hFF, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL led_load got=%h exp=3c", rd); end
        bus_xfer(1'b1, 8'hFE, 8'hAA, ap, as, apo, rd);
        bus_xfer(1'b0, 8'hFE, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL dip_readonly got=%h exp=00", rd); end
        bus_xfer(1'b1, 8'hFD, 8'h3F, ap, as, apo, rd);
        bus_xfer(1'b0, 8'hFD, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL buttons_readonly got=%h exp=00", rd); end
        checks++; if (LED !== 8'h3C) begin failures++; $display("FAIL led_kept got=%h exp=3c", LED); end
    endtask

    task automatic test_dip_debounce();
        logic ap, as, apo;
        logic [7:0] rd;
        // Input present from release; the debounced value moves on the 6th edge.
        DPSwitch = 8'h81;
        apply_reset();
        repeat (4) @(negedge CLK_12MHz);
        bus_xfer(1'b0, 8'hFE, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL dip_before_cycle6 got=%h exp=00", rd); end
        apply_reset();
        repeat (5) @(negedge CLK_12MHz);
        bus_xfer(1'b0, 8'hFE, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h81) begin failures++; $display("FAIL dip_at_cycle6 got=%h exp=81", rd); end
        // Three-cycle glitch on bit 0 is rejected.
        DPSwitch = 8'h80;
        repeat (3) @(negedge CLK_12MHz);
        DPSwitch = 8'h81;
        repeat (8) @(negedge CLK_12MHz);
        bus_xfer(1'b0, 8'hFE, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h81) begin failures++; $display("FAIL dip_glitch3 got=%h exp=81", rd); end
        // A four-cycle pulse on bit 7 is just long enough to pass.
        DPSwitch = 8'h01;
        repeat (4) @(negedge CLK_12MHz);
        DPSwitch = 8'h81;
        @(negedge CLK_12MHz);
        bus_xfer(1'b0, 8'hFE, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h01) begin failures++; $display("FAIL dip_pulse4 got=%h exp=01", rd); end
        repeat (10) @(negedge CLK_12MHz);
        bus_xfer(1'b0, 8'hFE, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h81) begin failures++; $display("FAIL dip_pulse4_return got=%h exp=81", rd); end
    endtask

    task automatic test_buttons();
        logic ap, as, apo;
        logic [7:0] rd;
        Switch = 6'b111011;
        repeat (10) @(negedge CLK_12MHz);
        bus_xfer(1'b0, 8'hFD, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h04) begin failures++; $display("FAIL btn2_live got=%h exp=04", rd); end
        bus_xfer(1'b0, 8'hFC, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h04) begin failures++; $display("FAIL btn2_event got=%h exp=04", rd); end
        bus_xfer(1'b0, 8'hFC, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL btn2_event_cleared got=%h exp=00", rd); end
    endtask

    task automatic test_event_in_resp();
        logic ap, as, apo;
        logic [7:0] rd;
        // Debounced edge of button 1 lands on the RESP edge of this read.
        Switch = 6'b111001;
        repeat (4) @(negedge CLK_12MHz);
        bus_xfer(1'b0, 8'hFC, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL race_read_old got=%h exp=00", rd); end
        bus_xfer(1'b0, 8'hFC, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h02) begin failures++; $display("FAIL race_event_kept got=%h exp=02", rd); end
        bus_xfer(1'b0, 8'hFD, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h06) begin failures++; $display("FAIL two_pressed got=%h exp=06", rd); end
        // Releases generate no events.
        Switch = 6'h3F;
        repeat (10) @(negedge CLK_12MHz);
        bus_xfer(1'b0, 8'hFD, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL released got=%h exp=00", rd); end
        bus_xfer(1'b0, 8'hFC, 8'h00, ap, as, apo, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL release_no_event got=%h exp=00", rd); end
    endtask

    task automatic test_back_to_back();
        logic ap, as, apo;
        logic [7:0] rd;
        logic [5:0] pattern;
        int         n_ack;
        bus_xfer(1'b1, 8'h20, 8'h5A, ap, as, apo, rd);
        pattern   = 6'b0;
        n_ack     = 0;
        bus.req   = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 8'h20;
        for (int k = 5; k >= 0; k--) begin
            @(negedge CLK_12MHz);
            pattern[k] = bus.ack;
            if (bus.ack === 1'b1) begin
                n_ack++;
                checks++; if (bus.rdata !== 8'h5A) begin failures++; $display("FAIL b2b_rdata got=%h exp=5a", bus.rdata); end
            end
        end
        bus.req = 1'b0;
        checks++; if (pattern !== 6'b101010) begin failures++; $display("FAIL b2b_pattern got=%b exp=101010", pattern); end
        checks++; if (n_ack != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n_ack); end
        @(negedge CLK_12MHz);
        checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL b2b_idle_ack got=%b exp=0", bus.ack); end
    endtask

    task automatic test_reset_mid();
        logic ap, as, apo;
        logic [7:0] rd;
        bus_xfer(1'b1, 8'h21, 8'h11, ap, as, apo, rd);
        bus_xfer(1'b1, 8'hFF, 8'h3C, ap, as, apo, rd);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 8'h21; bus.wdata = 8'h99;
        @(negedge CLK_12MHz);
        checks++; if (bus.ack !== 1'b1) begin failures++; $display("FAIL abort_in_resp got=%b exp=1", bus.ack); end
        Reset   = 1'b1;
        bus.req = 1'b0;
        bus.we  = 1'b0;
        #1;
        checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL abort_ack got=%b exp=0", bus.ack); end
        checks++; if (LED !== 8'h00) begin failures++; $display("FAIL abort_led got=%h exp=00", LED); end
        @(negedge CLK_12MHz);
        @(negedge CLK_12MHz);
        Reset = 1'b0;
        @(negedge CLK_12MHz);
        checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL post_reset_ack got=%b exp=0", bus.ack); end
        bus_xfer(1'b0, 8'h21, 8'h00, ap, as, apo, rd);
        checks++; if (as !== 1'b1) begin failures++; $display("FAIL post_reset_latency got=%b exp=1", as); end
        checks++; if (rd !== 8'h11) begin failures++; $display("FAIL aborted_store got=%h exp=11", rd); end
        checks++; if (LED !== 8'h00) begin failures++; $display("FAIL post_reset_led got=%h exp=00", LED); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led();
        test_dip_debounce();
        test_buttons();
        test_event_in_resp();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-side responder for the 8-bit RISC core's load/store/fetch port: services each core request over a req/ack handshake.
- Address map: data/instruction RAM, plus a small I/O window for the LED bank, the DIP switches and the push-buttons.
- The core becomes a pure initiator; all board I/O sits behind this block.
- Switch and button inputs are synchronized and debounced here. Button presses are latched as sticky events.

Parameters:
- RAM_WORDS, 252: RAM depth. Occupies addresses 0x00..RAM_WORDS-1; must be ≤252.
- DEBOUNCE_CYCLES, 120000: consecutive stable cycles needed before a debounced input changes (10 ms at 12 MHz).
- CNT_W, 17: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLK_12MHz input 1: system clock.
- Reset input 1: asynchronous, active-high reset.
- req input 1: core request; held until ack.
- we input 1: 1 = store, 0 = load/fetch; sampled with req.
- addr input 8: byte address.
- wdata input 8: store data.
- rdata output 8: load data; valid only while ack=1.
- ack output 1: one-cycle completion pulse.
- Switch input 6: push-buttons, active-low (0 = pressed).
- DPSwitch input 8: DIP switches, active-high.
- LED output 8: LED register, driven directly.

Behaviour:
- Clock and reset:
  - One clock; Reset is asynchronous and active-high.
  - Reset values: ack=0, rdata=0, LED=0, FSM=IDLE, debounced DPSwitch=0, debounced buttons=0 (released), event latch=0, all sync flops and debounce counters=0.
  - RAM contents are not reset.
- Address map:
  - 0x00..RAM_WORDS-1: RAM, read/write.
  - RAM_WORDS..0xFB: unmapped; reads return 0x00, writes are ignored, ack is still given.
  - 0xFC: button event latch {2'b00, ev[5:0]}; read-to-clear; writes ignored.
  - 0xFD: live debounced button state {2'b00, pressed[5:0]}; read-only.
  - 0xFE: debounced DPSwitch[7:0]; read-only.
  - 0xFF: LED register; read/write; reads return the current LED value.
- Handshake FSM:
  - IDLE: if req=1, capture addr/we/wdata and go to RESP.
  - RESP: ack=1 for exactly one cycle; rdata holds the read value for loads, 0x00 for stores. The store side effect commits on this same clock edge. Then go to IDLE.
  - Latency: ack is asserted in the cycle after req is first seen high. A held req starts a new transaction from IDLE, so peak throughput is one transfer every 2 cycles.
  - The initiator must drop req the cycle after ack unless it wants another transfer.
  - rdata returns to 0 when ack=0.
- Reset mid-transaction: asserting Reset in RESP aborts the transfer. A store in flight is not committed if Reset arrives before its RESP edge.
- Synchronizer: each Switch and DPSwitch bit passes through a 2-flop synchronizer before debounce.
- Debounce, per bit:
  - Counter clears whenever the synchronized value equals the debounced value.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced value takes the synchronized value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the output.
  - Total input-to-debounced latency = 2 + DEBOUNCE_CYCLES cycles.
- Button state: pressed[i] = ~debounced Switch[i].
- Event latch:
  - ev[i] sets on a 0→1 transition of pressed[i] and stays set until read.
  - A read of 0xFC returns the pre-clear value, and all bits clear on the RESP edge.
  - A new rising edge in that same RESP cycle wins: the bit remains set after the clear.
- Arithmetic: counters saturate at no point; they always clear at match. Address compare is full 8-bit.

Test Plan:
- Reset, then store 0xA5 to 0x10, then load 0x10 → ack one cycle after each req; load returns rdata=0xA5 with ack; LED stays 0x00.
- Store 0x3C to 0xFF → LED=0x3C on the RESP edge. Load 0xFF returns 0x3C. Store to 0xFE then load 0xFE → value unchanged, equals debounced DPSwitch.
- DEBOUNCE_CYCLES=4:
  - DPSwitch=0x81 held, load 0xFE → 0x81 from cycle 6 onward, 0x00 before.
  - A 3-cycle pulse on DPSwitch[0] → 0xFE never changes.
- DEBOUNCE_CYCLES=4: press Switch[2] (drive 0) long enough → 0xFD reads 0x04. Load 0xFC → 0x04; a second load of 0xFC → 0x00.
- Press Switch[1] timed so its debounced edge lands in the 0xFC read's RESP cycle → that read returns the old value, and the next read returns 0x02.
- req held high for 6 cycles with addr=0x20 → exactly 3 ack pulses on alternating cycles. Assert Reset during a RESP of a store to 0x21 → ack=0 and LED=0 immediately; FSM in IDLE after Reset.
